// File: rtl/contador_modulo_m_cascada.sv
// Cascade of D digits. Each digit counts modulo M.
// Supports up/down counting, parallel load with clamping, wrap or saturate mode, and a registered overflow pulse.
module contador_modulo_m_cascada #(
    parameter int M   = 10,
    parameter int D   = 2,
    parameter bit SAT = 1'b0,
    localparam int W  = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cnt,
    input  logic           dir,
    input  logic           load,
    input  logic [D*W-1:0] d,
    output logic [D*W-1:0] q,
    output logic           tc,
    output logic           ov
);

    localparam logic [W-1:0] DMAX = W'(M - 1);

    logic [D*W-1:0] q_q, q_d;
    logic           ov_q, ov_d;
    logic           at_top, at_bot;
    logic           chain;
    logic [W-1:0]   dig;

    always_comb begin
        at_top = 1'b1;
        at_bot = 1'b1;
        for (int i = 0; i < D; i++) begin
            at_top = at_top & (q_q[i*W +: W] == DMAX);
            at_bot = at_bot & (q_q[i*W +: W] == '0);
        end
        tc = cnt & (dir ? at_bot : at_top);
    end

    // chain is the ripple carry (up) or borrow (down) entering each digit.
    always_comb begin
        q_d   = q_q;
        ov_d  = 1'b0;
        chain = 1'b1;
        dig   = '0;
        if (load) begin
            for (int i = 0; i < D; i++) begin
                dig = d[i*W +: W];
                q_d[i*W +: W] = (dig > DMAX) ? DMAX : dig;
            end
        end else if (cnt) begin
            if (SAT && tc) begin
                ov_d = 1'b1;
            end else begin
                ov_d = tc;
                for (int i = 0; i < D; i++) begin
                    dig = q_q[i*W +: W];
                    if (chain) begin
                        if (!dir) begin
                            q_d[i*W +: W] = (dig == DMAX) ? '0 : dig + W'(1);
                            chain         = (dig == DMAX);
                        end else begin
                            q_d[i*W +: W] = (dig == '0) ? DMAX : dig - W'(1);
                            chain         = (dig == '0);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            ov_q <= ov_d;
        end
    end

    assign q  = q_q;
    assign ov = ov_q;

endmodule
